fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parameterised instruction-fetch front end for the accumulator processor.
- Owns the program counter and prefetches from the combinational instruction ROM into a DEPTH-entry queue.
- Hands {instruction, PC} to the decode/execute side with a valid/ready handshake.
- Supports jump/branch redirect with queue flush, halt-opcode detection and a saturating cycle counter, replacing the bare PC + cycle_ct of the single-cycle core.

Parameters:
- IW, 9, instruction width in bits.
- AW, 10, PC / instruction-address width in bits.
- DEPTH, 4, queue entries; power of two, at least 2.
- HALT_OP, 9'h1FF, instruction encoding that halts the machine (IW bits).
- CW, 16, cycle-counter width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- start_n  in  1  reset, asynchronous assert, active-low.
- imem_addr  out  AW  address to instruction ROM; equals fetch_pc.
- imem_data  in  IW  ROM data for imem_addr, same cycle (combinational ROM).
- inst_valid  out  1  queue head is valid.
- inst  out  IW  head instruction.
- inst_pc  out  AW  PC of head instruction.
- inst_ready  in  1  consumer accepts head this cycle.
- redirect_en  in  1  taken jump/branch; flush and refetch.
- redirect_target  in  AW  new fetch PC.
- halt  out  1  sticky; HALT_OP has been consumed.
- cycle_ct  out  CW  cycles elapsed since reset while not halted.

Behaviour:
- Reset (start_n=0, async): fetch_pc=0, queue empty, fetch_stop=0, halt=0, cycle_ct=0. Consequently inst_valid=0, and inst/inst_pc read as 0.
- pop = inst_valid & inst_ready.
- push = !redirect_en & !fetch_stop & !halt & (count<DEPTH | pop). Full with a simultaneous pop still pushes, so there is no bubble.
- On push: enqueue {imem_data, fetch_pc}; fetch_pc <= fetch_pc+1, wrapping from 2^AW-1 to 0.
  - If the pushed imem_data == HALT_OP, set fetch_stop=1. The halt instruction is enqueued; nothing after it is fetched.
- Outputs are driven from the head entry, registered storage only; no ROM-to-consumer combinational path. Latency from fetch_pc update to inst_valid is 1 cycle when the queue was empty.
- On pop: advance head, count-1. If the popped inst == HALT_OP, set halt=1 on that edge.
- Redirect (redirect_en=1 and halt=0):
  - Flush all entries; count=0; fetch_pc <= redirect_target; fetch_stop=0.
  - Any push that cycle is discarded.
  - A pop in the same cycle is considered consumed; this is the branch instruction itself.
  - inst_valid=0 the following cycle; the target instruction is valid 2 cycles after the redirect edge.
- Redirect while halt=1 is ignored.
- halt=1: no push, no state change except pops. halt clears only on reset.
- cycle_ct increments every cycle while halt=0 and saturates at 2^CW-1.
- Asserting reset mid-operation discards queue contents and counters immediately.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds output retired_ct (CW), incremented on every pop and saturating, reset 0.
  - Adds output flush_ct (CW), incremented on every honoured redirect that discards at least one valid entry or push, saturating, reset 0.
- Undefined: neither port exists; no counter logic.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_entry_t struct {logic [IW-1:0] inst; logic [AW-1:0] pc;}, parameterised via localparams mirrored from defaults.
  - HALT_OP default constant.
- Sub-module fetch_fifo: circular buffer of fetch_entry_t with push/pop/flush and count.
- fetch_queue holds the PC, fetch_stop, halt and counter logic.

Test Plan:
- ROM 0..7 = non-halt ops, inst_ready=1 continuously, after reset release -> inst_valid rises 1 cycle later; inst_pc sequence 0,1,2,3,... one per cycle; cycle_ct = cycles since release.
- inst_ready=0 for 10 cycles -> count reaches 4, fetch_pc=4, imem_addr holds 4. Ready re-asserted -> pcs 0..3 then 4 with no gap or duplicate.
- Redirect on the cycle inst_pc=2 is popped, target=10'h3F0 -> entries 3..n dropped; next valid inst_pc=0x3F0, two edges later.
- fetch_pc=10'h3FF -> next fetched pc is 0x000 (wrap).
- ROM[5]=HALT_OP, ROM[6]=other -> pc 6 is never enqueued. halt=1 on the edge after pc 5 is popped; cycle_ct freezes; a later redirect has no effect.
- Reset pulsed low mid-run with a full queue -> inst_valid=0, halt=0, cycle_ct=0 immediately; refetch starts from pc 0. With FETCH_PERF_EN defined, retired_ct also returns to 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default constants for the instruction-fetch front end.
//   FETCH_IW / FETCH_AW / FETCH_CW : default instruction, address and counter widths
//   FETCH_HALT_OP                  : default encoding of the halt instruction
//   fetch_entry_t                  : one queue entry, {instruction, pc}, at default widths
package fetch_pkg;

  localparam int unsigned FETCH_IW = 9;
  localparam int unsigned FETCH_AW = 10;
  localparam int unsigned FETCH_CW = 16;

  localparam logic [FETCH_IW-1:0] FETCH_HALT_OP = 9'h1FF;

  typedef struct packed {
    logic [FETCH_IW-1:0] inst;
    logic [FETCH_AW-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of fetch entries with push, pop, flush and occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, pop  : enqueue wdata / dequeue head (callers never pop when empty or push when full without pop)
//   flush      : drop every entry and any push in the same cycle
//   wdata      : entry to enqueue
//   rdata      : head entry, '0 while empty
//   count      : current number of entries
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  entry_t                   wdata,
  output entry_t                   rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  entry_t            mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  // Storage is not reset; gate the head so an empty queue reads as zero.
  assign rdata = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end for the accumulator processor.
// Owns the PC, prefetches from a combinational ROM into a DEPTH-entry queue and
// hands {inst, pc} to decode with valid/ready. Handles redirect+flush, halt
// detection and a saturating cycle counter.
//   CLK, start_n        : clock, asynchronous active-low reset
//   imem_addr/imem_data : ROM address (= fetch pc) and same-cycle ROM data
//   inst_valid/inst/inst_pc/inst_ready : head of queue handshake
//   redirect_en/redirect_target        : taken jump/branch, flush and refetch
//   halt                : sticky, set once the halt opcode is consumed
//   cycle_ct            : saturating cycles since reset while not halted
// Optional macro FETCH_PERF_EN adds retired_ct and flush_ct saturating counters.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned     IW      = FETCH_IW,
  parameter int unsigned     AW      = FETCH_AW,
  parameter int unsigned     DEPTH   = 4,
  parameter logic [IW-1:0]   HALT_OP = IW'(FETCH_HALT_OP),
  parameter int unsigned     CW      = FETCH_CW
) (
  input  logic          CLK,
  input  logic          start_n,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  output logic          inst_valid,
  output logic [IW-1:0] inst,
  output logic [AW-1:0] inst_pc,
  input  logic          inst_ready,
  input  logic          redirect_en,
  input  logic [AW-1:0] redirect_target,
  output logic          halt,
  output logic [CW-1:0] cycle_ct
`ifdef FETCH_PERF_EN
  ,
  output logic [CW-1:0] retired_ct,
  output logic [CW-1:0] flush_ct
`endif
);

  localparam int unsigned CNTW = $clog2(DEPTH) + 1;
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] ONE  = CNTW'(1);

  typedef struct packed {
    logic [IW-1:0] inst;
    logic [AW-1:0] pc;
  } entry_t;

  logic [AW-1:0]   fetch_pc;
  logic            fetch_stop;
  logic [CNTW-1:0] count;
  entry_t          head;
  entry_t          wdata;
  logic            pop;
  logic            fetch_ok;
  logic            push;
  logic            redir;

  assign imem_addr  = fetch_pc;
  assign inst_valid = (count != '0);
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

  assign pop      = inst_valid & inst_ready;
  // Fetch would proceed this cycle if no redirect were present.
  assign fetch_ok = !fetch_stop && !halt && ((count != FULL) || pop);
  assign push     = !redirect_en && fetch_ok;
  assign redir    = redirect_en && !halt;
  assign wdata    = '{inst: imem_data, pc: fetch_pc};

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (start_n),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .wdata (wdata),
    .rdata (head),
    .count (count)
  );

  always_ff @(posedge CLK or negedge start_n) begin
    if (!start_n) begin
      fetch_pc   <= '0;
      fetch_stop <= 1'b0;
      halt       <= 1'b0;
      cycle_ct   <= '0;
    end else begin
      if (redir) begin
        fetch_pc   <= redirect_target;
        fetch_stop <= 1'b0;
      end else if (push) begin
        fetch_pc <= fetch_pc + 1'b1;
        if (imem_data == HALT_OP) fetch_stop <= 1'b1;
      end
      if (pop && (head.inst == HALT_OP)) halt <= 1'b1;
      if (!halt && (cycle_ct != '1)) cycle_ct <= cycle_ct + 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  logic drop_entries;

  // The entry popped alongside a redirect is the branch itself, not a discard.
  assign drop_entries = pop ? (count > ONE) : (count != '0);

  always_ff @(posedge CLK or negedge start_n) begin
    if (!start_n) begin
      retired_ct <= '0;
      flush_ct   <= '0;
    end else begin
      if (pop && (retired_ct != '1)) retired_ct <= retired_ct + 1'b1;
      if (redir && (drop_entries || fetch_ok) && (flush_ct != '1))
        flush_ct <= flush_ct + 1'b1;
    end
  end
`else
  logic unused_one;
  assign unused_one = ^ONE;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        CLK;
  logic        start_n;
  logic [9:0]  imem_addr;
  logic [8:0]  imem_data;
  logic        inst_valid;
  logic [8:0]  inst;
  logic [9:0]  inst_pc;
  logic        inst_ready;
  logic        redirect_en;
  logic [9:0]  redirect_target;
  logic        halt;
  logic [15:0] cycle_ct;
`ifdef FETCH_PERF_EN
  logic [15:0] retired_ct;
  logic [15:0] flush_ct;
`endif

  logic [8:0] rom [1024];
  int unsigned pass_ct = 0;
  int unsigned chk_ct  = 0;

  assign imem_data = rom[imem_addr];

  fetch_queue #(
    .IW      (9),
    .AW      (10),
    .DEPTH   (4),
    .HALT_OP (9'h1FF),
    .CW      (16)
  ) dut (
    .CLK             (CLK),
    .start_n         (start_n),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .redirect_en     (redirect_en),
    .redirect_target (redirect_target),
    .halt            (halt),
    .cycle_ct        (cycle_ct)
`ifdef FETCH_PERF_EN
    ,
    .retired_ct      (retired_ct),
    .flush_ct        (flush_ct)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_ct++;
    if (got === exp) pass_ct++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = {1'b0, i[7:0]};
    start_n         = 1'b0;
    inst_ready      = 1'b0;
    redirect_en     = 1'b0;
    redirect_target = '0;
    tick();
    tick();

    // reset state
    check("rst_valid", inst_valid, 0);
    check("rst_inst",  inst,       0);
    check("rst_pc",    inst_pc,    0);
    check("rst_addr",  imem_addr,  0);
    check("rst_halt",  halt,       0);
    check("rst_cycle", cycle_ct,   0);

    // streaming, one instruction per cycle
    start_n    = 1'b1;
    inst_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("pipe_valid", inst_valid, 1);
      check("pipe_pc",    inst_pc,    k - 1);
      check("pipe_inst",  inst,       {1'b0, 8'(k - 1)});
      check("pipe_cycle", cycle_ct,   k);
    end

    // redirect while pc 2 is being consumed
    redirect_en     = 1'b1;
    redirect_target = 10'h3F0;
    tick();
    redirect_en = 1'b0;
    check("redir_bubble", inst_valid, 0);
    check("redir_addr",   imem_addr,  10'h3F0);
`ifdef FETCH_PERF_EN
    check("perf_retired_redir", retired_ct, 3);
    check("perf_flush_redir",   flush_ct,   1);
`endif
    tick();
    check("redir_valid", inst_valid, 1);
    check("redir_pc",    inst_pc,    10'h3F0);
    check("redir_inst",  inst,       9'h0F0);
    repeat (15) tick();
    check("wrap_last_pc", inst_pc, 10'h3FF);
    tick();
    check("wrap_pc",    inst_pc,    10'h000);
    check("wrap_valid", inst_valid, 1);
    check("wrap_inst",  inst,       9'h000);

    // backpressure fills the queue
    start_n    = 1'b0;
    inst_ready = 1'b0;
    tick();
    start_n = 1'b1;
    repeat (10) tick();
    check("bp_valid", inst_valid, 1);
    check("bp_pc",    inst_pc,    0);
    check("bp_addr",  imem_addr,  4);
    check("bp_cycle", cycle_ct,   10);
    inst_ready = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      check("bp_seq_pc",    inst_pc,    k);
      check("bp_seq_valid", inst_valid, 1);
      tick();
    end
    inst_ready = 1'b0;
    repeat (5) tick();
    check("fill_addr", imem_addr, 10);
    check("fill_pc",   inst_pc,   6);
`ifdef FETCH_PERF_EN
    check("perf_retired_fill", retired_ct, 6);
`endif

    // asynchronous reset with a full queue
    start_n = 1'b0;
    #1;
    check("arst_valid", inst_valid, 0);
    check("arst_halt",  halt,       0);
    check("arst_cycle", cycle_ct,   0);
    check("arst_addr",  imem_addr,  0);
    check("arst_pc",    inst_pc,    0);
`ifdef FETCH_PERF_EN
    check("perf_retired_arst", retired_ct, 0);
`endif

    // halt at pc 5
    rom[5] = 9'h1FF;
    tick();
    start_n    = 1'b1;
    inst_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("halt_seq_pc", inst_pc, k - 1);
    end
    check("halt_head_inst", inst,      9'h1FF);
    check("halt_pre",       halt,      0);
    check("halt_stop_addr", imem_addr, 6);
    tick();
    check("halt_set",   halt,       1);
    check("halt_empty", inst_valid, 0);
    check("halt_cycle", cycle_ct,   7);
    check("halt_addr",  imem_addr,  6);
    repeat (5) tick();
    check("halt_freeze_cycle", cycle_ct,   7);
    check("halt_freeze_valid", inst_valid, 0);
    redirect_en     = 1'b1;
    redirect_target = 10'h100;
    tick();
    redirect_en = 1'b0;
    tick();
    check("halt_redir_addr",  imem_addr,  6);
    check("halt_redir_valid", inst_valid, 0);
    check("halt_sticky",      halt,       1);
`ifdef FETCH_PERF_EN
    check("perf_flush_halt",   flush_ct,   0);
    check("perf_retired_halt", retired_ct, 6);
`endif

    // reset clears halt
    start_n = 1'b0;
    #1;
    check("halt_rst_halt",  halt,     0);
    check("halt_rst_cycle", cycle_ct, 0);

    $display("%0d/%0d checks passed", pass_ct, chk_ct);
    $finish;
  end

endmodule
